// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, RV32I funct3 values,
// response error codes, controller states and the request/decode bundles.
package lsu_pkg;

  // mem_size encodings
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // RV32I load/store funct3 (stores only use B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // resp_err codes
  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_MIS   = 2'b01;
  localparam logic [1:0] ERR_FAULT = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_SPLIT,
    ST_RESP
  } state_t;

  // Raw request fields from the execute stage
  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] wdata;
  } lsu_req_t;

  // Decoded request: effective address, access shape and error flags
  typedef struct packed {
    logic [31:0] ea;
    logic [1:0]  size;
    logic        sgn;
    logic        misaligned;
    logic        fault;
    logic        illegal;
  } lsu_dec_t;

  // Number of bytes touched by an access of the given size
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Sign- or zero-extend the low byte/half of d; words pass through
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                         input logic sgn);
    case (sz)
      SZ_B:    return {{24{sgn & d[7]}}, d[7:0]};
      SZ_H:    return {{16{sgn & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_addr_chk.sv
// Combinational request decode: effective address, size/signedness from
// funct3, and the three independent error conditions (illegal, fault,
// misaligned). Priority between them is resolved by the controller.
module lsu_addr_chk
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  lsu_req_t req,
  output lsu_dec_t dec
);

  logic [32:0] last_byte;

  // Decode funct3, form ea and test alignment/range of the touched bytes
  always_comb begin
    dec            = '0;
    dec.ea         = req.base + req.offset;
    dec.size       = SZ_B;
    dec.sgn        = 1'b0;
    dec.illegal    = 1'b0;
    case (req.funct3)
      F3_B:    begin dec.size = SZ_B; dec.sgn = ~req.is_store; end
      F3_H:    begin dec.size = SZ_H; dec.sgn = ~req.is_store; end
      F3_W:    begin dec.size = SZ_W; dec.sgn = ~req.is_store; end
      F3_BU:   begin dec.size = SZ_B; dec.illegal = req.is_store; end
      F3_HU:   begin dec.size = SZ_H; dec.illegal = req.is_store; end
      default: dec.illegal = 1'b1;
    endcase
    // 33-bit sum so an access running past 2^32 lands above MEM_BYTES too
    last_byte      = {1'b0, dec.ea} + 33'(size_bytes(dec.size)) - 33'd1;
    dec.fault      = last_byte >= 33'(MEM_BYTES);
    dec.misaligned = ((dec.size == SZ_H) && dec.ea[0]) ||
                     ((dec.size == SZ_W) && (dec.ea[1:0] != 2'b00));
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one request at a time, drives the data
// memory strobes (single access or a byte-by-byte split for misaligned
// accesses) and returns the result on a held valid/ready response channel.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES        = 1024,
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic        mem_signed,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  state_t      state, state_nxt;
  lsu_req_t    req;
  lsu_dec_t    dec;
  logic [1:0]  err_nxt;

  // Latched request
  logic [31:0] ea_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic        store_q;
  logic [1:0]  err_q;
  logic [31:0] res_q;
  logic [1:0]  k_q;      // byte index during a split access

  logic [1:0]  k_last;
  logic [31:0] res_byte;

  assign req = '{is_store: req_is_store, funct3: req_funct3, base: req_base,
                 offset: req_offset, wdata: req_wdata};

  lsu_addr_chk #(.MEM_BYTES(MEM_BYTES)) u_chk (
    .req (req),
    .dec (dec)
  );

  // Error priority: illegal funct3, then range fault, then misalignment
  // (misalignment is only an error when splitting is disabled)
  always_comb begin
    err_nxt = ERR_OK;
    if (dec.illegal)
      err_nxt = ERR_ILL;
    else if (dec.fault)
      err_nxt = ERR_FAULT;
    else if (dec.misaligned && !SPLIT_MISALIGNED)
      err_nxt = ERR_MIS;
  end

  // Result with the current split byte merged into lane k
  assign k_last = (size_q == SZ_W) ? 2'd3 : 2'd1;
  always_comb begin
    res_byte                     = res_q;
    res_byte[{k_q, 3'b000} +: 8] = mem_rdata[7:0];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next state and all strobes; strobes are only ever raised in ACCESS/SPLIT
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_size   = SZ_B;
    mem_signed = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (err_nxt != ERR_OK)
            state_nxt = ST_RESP;
          else if (dec.misaligned)
            state_nxt = ST_SPLIT;
          else
            state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_addr   = ea_q;
        mem_size   = size_q;
        mem_signed = sgn_q;
        mem_read   = ~store_q;
        mem_write  = store_q;
        mem_wdata  = store_q ? wdata_q : '0;
        state_nxt  = ST_RESP;
      end
      ST_SPLIT: begin
        mem_addr  = ea_q + 32'(k_q);
        mem_read  = ~store_q;
        mem_write = store_q;
        mem_wdata = store_q ? {24'b0, wdata_q[{k_q, 3'b000} +: 8]} : '0;
        if (k_q == k_last)
          state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch on accept, load-result capture during ACCESS/SPLIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ea_q    <= '0;
      wdata_q <= '0;
      size_q  <= SZ_B;
      sgn_q   <= 1'b0;
      store_q <= 1'b0;
      err_q   <= ERR_OK;
      res_q   <= '0;
      k_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            ea_q    <= dec.ea;
            wdata_q <= req_wdata;
            size_q  <= dec.size;
            sgn_q   <= dec.sgn;
            store_q <= req_is_store;
            err_q   <= err_nxt;
            res_q   <= '0;
            k_q     <= '0;
          end
        end
        ST_ACCESS: begin
          if (!store_q)
            res_q <= extend(mem_rdata, size_q, sgn_q);
        end
        ST_SPLIT: begin
          if (!store_q)
            res_q <= (k_q == k_last) ? extend(res_byte, size_q, sgn_q) : res_byte;
          k_q <= k_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Response fields read as zero whenever no response is presented
  assign resp_rdata = resp_valid ? res_q : '0;
  assign resp_err   = resp_valid ? err_q : ERR_OK;
  assign busy       = (state != ST_IDLE);

endmodule
